ucsbece154a_datapath_mc: RTL and testbench
==========================================

UCSBECE154A_DATAPATH_MC -- requirements
Module: ucsbece154a_datapath_mc

Interface
REQ-001 Parameter NREGS, default 32, architectural register count; legal values 16 (RV32E) or 32.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 PCWrite_i  input  1  PC load enable.
REQ-006 AdrSrc_i  input  1  memory address select: 0 = PC, 1 = Result.
REQ-007 IRWrite_i  input  1  IR and OldPC load enable.
REQ-008 RegWrite_i  input  1  register file write enable.
REQ-009 ImmSrc_i  input  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U; other values give 0.
REQ-010 ALUSrcA_i  input  2  ALU A select: 00 PC, 01 OldPC, 10 A register, 11 zero.
REQ-011 ALUSrcB_i  input  2  ALU B select: 00 B register, 01 ImmExt, 10 constant 4, 11 zero.
REQ-012 ALUControl_i  input  3  ALU operation, encoded as for ucsbece154a_alu.
REQ-013 ResultSrc_i  input  2  Result select: 00 ALUOut, 01 Data, 10 ALU result, 11 ImmExt.
REQ-014 instr_done_i  input  1  controller pulse marking the final cycle of an instruction.
REQ-015 mem_addr_o, mem_wdata_o, mem_rdata_i  out/out/in  32 each  unified memory address, store data (B register), and read data.
REQ-016 mem_ready_i  input  1  memory ready; 0 stalls the datapath.
REQ-017 instr_o  output  32  current IR contents, fed to the controller.
REQ-018 pc_o  output  32  current PC.
REQ-019 zero_o  output  1  ALU zero flag, combinational.
REQ-020 mcycle_o, minstret_o  output  64 each  performance counters (see Configuration).

Function
REQ-021 Each edge with mem_ready_i=1 SHALL capture: A<=rf[IR[19:15]]; B<=rf[IR[24:20]]; ALUOut<=ALU result; Data<=mem_rdata_i.
REQ-022 With mem_ready_i=1 and IRWrite_i=1, an edge SHALL load IR<=mem_rdata_i and OldPC<=PC.
REQ-023 With mem_ready_i=1 and PCWrite_i=1, an edge SHALL load PC<=Result.
REQ-024 With mem_ready_i=1 and RegWrite_i=1, an edge SHALL write rf[IR[11:7]]<=Result.
REQ-025 With mem_ready_i=0, all state SHALL hold: PC, OldPC, IR, A, B, ALUOut, Data, rf and minstret.
REQ-026 Reads of x0 SHALL return 0, and writes to x0 SHALL be ignored.
REQ-027 When NREGS=16, reads of any address with bit 4 set SHALL return 0, and writes to such addresses SHALL be ignored.
REQ-028 If the same edge writes rd and captures a read of that register, A/B SHALL capture the pre-write value; there is no bypass.
REQ-029 ImmExt SHALL be sign-extended from IR[31] per RISC-V I/S/B/J formats; the U format gives {IR[31:12],12'b0}.
REQ-030 All arithmetic SHALL be 32-bit modulo 2^32; PC+4 wraps 32'hFFFF_FFFC to 0.
REQ-031 mem_addr_o, Result, zero_o and ImmExt SHALL be combinational, so a load address is valid in the same cycle it is selected.

Reset
REQ-032 Reset SHALL force PC=OldPC=RESET_PC, IR=32'h0000_0013 (nop), A=B=ALUOut=Data=0, all registers=0, and mcycle_o=minstret_o=0.
REQ-033 Reset asserted mid-instruction or mid-stall SHALL abort immediately; state after deassertion SHALL equal post-reset state.

Configuration
REQ-034 With macro UCSBECE154A_MC_PERF_EN defined, mcycle SHALL increment on every edge out of reset, stall cycles included.
REQ-035 With UCSBECE154A_MC_PERF_EN defined, minstret SHALL increment on each edge with instr_done_i=1 and mem_ready_i=1.
REQ-036 With UCSBECE154A_MC_PERF_EN defined, both counters SHALL wrap from 2^64-1 to 0.
REQ-037 Without UCSBECE154A_MC_PERF_EN, mcycle_o and minstret_o SHALL be constant 0 and no counter flops SHALL be generated.

Verification
REQ-038 Fetch: RESET_PC=0x100, mem_rdata_i=0x00500093, AdrSrc_i=0, IRWrite_i=1, ALUSrcA_i=00, ALUSrcB_i=10, ResultSrc_i=10, PCWrite_i=1 -> instr_o=0x00500093, pc_o=0x104, OldPC=0x100.
REQ-039 addi x1,x0,5 executed over the full multicycle sequence -> rf[1]=5; then a write to x0 -> rf[0] still reads 0.
REQ-040 Stall: mem_ready_i=0 for 3 cycles during fetch -> pc_o and instr_o unchanged; with PERF_EN, mcycle advances by 3 and minstret by 0.
REQ-041 NREGS=16: write 0xDEAD to x17 -> reading x17 returns 0 and x1 is unchanged.
REQ-042 PERF_EN: preload mcycle=64'hFFFF_FFFF_FFFF_FFFF -> 0 after one edge.
REQ-043 Async reset asserted between clock edges -> pc_o=RESET_PC and instr_o=0x00000013 immediately, before the next edge.

Source files
------------

// File: rtl/ucsbece154a_datapath_mc.sv
// Multicycle RV32I/RV32E datapath: PC, IR/OldPC, register file, ALU, operand and result muxes.
// Optional mcycle/minstret counters are built only when UCSBECE154A_MC_PERF_EN is defined.
module ucsbece154a_datapath_mc #(
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite_i,
  input  logic        AdrSrc_i,
  input  logic        IRWrite_i,
  input  logic        RegWrite_i,
  input  logic [2:0]  ImmSrc_i,
  input  logic [1:0]  ALUSrcA_i,
  input  logic [1:0]  ALUSrcB_i,
  input  logic [2:0]  ALUControl_i,
  input  logic [1:0]  ResultSrc_i,
  input  logic        instr_done_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        zero_o,
  output logic [63:0] mcycle_o,
  output logic [63:0] minstret_o
);

  localparam int AW = $clog2(NREGS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, data_q, data_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] rf_d [NREGS];

  logic [31:0] imm_ext, src_a, src_b, alu_result, result, rd1, rd2;
  logic [4:0]  rs1, rs2, rd;

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];

  // x0 and (for RV32E) any address with bit 4 set are not real registers.
  function automatic logic reg_ok(input logic [4:0] adr);
    return (adr != 5'd0) && (int'(adr) < NREGS);
  endfunction

  assign rd1 = reg_ok(rs1) ? rf_q[rs1[AW-1:0]] : 32'd0;
  assign rd2 = reg_ok(rs2) ? rf_q[rs2[AW-1:0]] : 32'd0;

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    imm_ext = 32'd0;
    case (ImmSrc_i)
      3'b000:  imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
      3'b001:  imm_ext = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'b010:  imm_ext = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'b011:  imm_ext = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      3'b100:  imm_ext = {ir_q[31:12], 12'd0};
      default: imm_ext = 32'd0;
    endcase
  end

  always_comb begin
    src_a = 32'd0;
    case (ALUSrcA_i)
      2'b00:   src_a = pc_q;
      2'b01:   src_a = old_pc_q;
      2'b10:   src_a = a_q;
      default: src_a = 32'd0;
    endcase
    src_b = 32'd0;
    case (ALUSrcB_i)
      2'b00:   src_b = b_q;
      2'b01:   src_b = imm_ext;
      2'b10:   src_b = 32'd4;
      default: src_b = 32'd0;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (ALUControl_i)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'd0;
    endcase
  end

  always_comb begin
    result = 32'd0;
    case (ResultSrc_i)
      2'b00:   result = alu_out_q;
      2'b01:   result = data_q;
      2'b10:   result = alu_result;
      default: result = imm_ext;
    endcase
  end

  assign zero_o      = (alu_result == 32'd0);
  assign mem_addr_o  = AdrSrc_i ? result : pc_q;
  assign mem_wdata_o = b_q;
  assign instr_o     = ir_q;
  assign pc_o        = pc_q;

  // A stalled memory freezes every architectural and pipeline register.
  always_comb begin
    pc_d      = pc_q;
    old_pc_d  = old_pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    data_d    = data_q;
    rf_d      = rf_q;
    if (mem_ready_i) begin
      a_d       = rd1;
      b_d       = rd2;
      alu_out_d = alu_result;
      data_d    = mem_rdata_i;
      if (IRWrite_i) begin
        ir_d     = mem_rdata_i;
        old_pc_d = pc_q;
      end
      if (PCWrite_i) pc_d = result;
      if (RegWrite_i && reg_ok(rd)) rf_d[rd[AW-1:0]] = result;
    end
  end

  // NOTE: sequential state is assigned with <= so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      old_pc_q  <= RESET_PC;
      ir_q      <= NOP;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
      data_q    <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      old_pc_q  <= old_pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      data_q    <= data_d;
    end
  end

  // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'd0;
    end else begin
      rf_q <= rf_d;
    end
  end

`ifdef UCSBECE154A_MC_PERF_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instr_done_i & mem_ready_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle_o   = mcycle_q;
  assign minstret_o = minstret_q;
`else
  logic unused_instr_done;
  assign unused_instr_done = instr_done_i;
  assign mcycle_o   = 64'd0;
  assign minstret_o = 64'd0;
`endif

endmodule

// File: tb/tb_ucsbece154a_datapath_mc.sv
// Scoreboard bench for ucsbece154a_datapath_mc: an RV32I and an RV32E instance share stimulus.
// Perf-counter checks follow UCSBECE154A_MC_PERF_EN; without it the counters must read 0.
module tb_ucsbece154a_datapath_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, adr_src, ir_write, reg_write, instr_done, mem_ready;
  logic [2:0]  imm_src, alu_ctl;
  logic [1:0]  src_a, src_b, res_src;
  logic [31:0] rdata;

  logic [31:0] addr32, wdata32, instr32, pc32, addr16, wdata16, instr16, pc16;
  logic        zero32, zero16;
  logic [63:0] mcyc32, minst32, mcyc16, minst16;

  always #5 clk = ~clk;

  ucsbece154a_datapath_mc #(.NREGS(32), .RESET_PC(32'h100)) u_dut (
    .clk(clk), .reset(reset), .PCWrite_i(pc_write), .AdrSrc_i(adr_src),
    .IRWrite_i(ir_write), .RegWrite_i(reg_write), .ImmSrc_i(imm_src),
    .ALUSrcA_i(src_a), .ALUSrcB_i(src_b), .ALUControl_i(alu_ctl),
    .ResultSrc_i(res_src), .instr_done_i(instr_done), .mem_addr_o(addr32),
    .mem_wdata_o(wdata32), .mem_rdata_i(rdata), .mem_ready_i(mem_ready),
    .instr_o(instr32), .pc_o(pc32), .zero_o(zero32),
    .mcycle_o(mcyc32), .minstret_o(minst32)
  );

  ucsbece154a_datapath_mc #(.NREGS(16), .RESET_PC(32'h100)) u_dut16 (
    .clk(clk), .reset(reset), .PCWrite_i(pc_write), .AdrSrc_i(adr_src),
    .IRWrite_i(ir_write), .RegWrite_i(reg_write), .ImmSrc_i(imm_src),
    .ALUSrcA_i(src_a), .ALUSrcB_i(src_b), .ALUControl_i(alu_ctl),
    .ResultSrc_i(res_src), .instr_done_i(instr_done), .mem_addr_o(addr16),
    .mem_wdata_o(wdata16), .mem_rdata_i(rdata), .mem_ready_i(mem_ready),
    .instr_o(instr16), .pc_o(pc16), .zero_o(zero16),
    .mcycle_o(mcyc16), .minstret_o(minst16)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference counters for the perf build, derived from the stimulus itself.
  logic [63:0] cyc_model, inst_model;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_model  <= 64'd0;
      inst_model <= 64'd0;
    end else begin
      cyc_model  <= cyc_model + 64'd1;
      if (instr_done && mem_ready) inst_model <= inst_model + 64'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: got 0x%0h, want nothing queued", act);
    end else begin
      e = sb.pop_front();
      check(e.tag, act, e.val);
    end
  endtask

  task automatic exp2(input string tag, input logic [63:0] e32, input logic [63:0] e16);
    push({tag, "_32"}, e32);
    push({tag, "_16"}, e16);
  endtask

  task automatic obs2(input logic [63:0] a32, input logic [63:0] a16);
    pop_check(a32);
    pop_check(a16);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_write = 0; adr_src = 0; ir_write = 0; reg_write = 0; instr_done = 0;
    mem_ready = 1; imm_src = 3'b000; alu_ctl = 3'b000;
    src_a = 2'b00; src_b = 2'b00; res_src = 2'b00;
  endtask

  task automatic fetch_ctl();
    adr_src = 0; ir_write = 1; src_a = 2'b00; src_b = 2'b10;
    alu_ctl = 3'b000; res_src = 2'b10; pc_write = 1;
  endtask

  // Route the A register onto mem_addr_o through the ALU (A + 0).
  task automatic show_a();
    idle();
    src_a = 2'b10; src_b = 2'b11; res_src = 2'b10; adr_src = 1;
    #1;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    idle();
    ir_write = 1;
    rdata = instr;
    tick();
    ir_write = 0;
  endtask

  task automatic read_reg(input logic [4:0] r, input logic [31:0] e32, input logic [31:0] e16);
    exp2($sformatf("x%0d", r), {32'd0, e32}, {32'd0, e16});
    load_ir({12'd0, r, 3'b000, 5'd0, 7'h13});
    tick();
    show_a();
    obs2({32'd0, addr32}, {32'd0, addr16});
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
    load_ir({20'd0, rd, 7'h13});
    rdata = val;
    tick();
    res_src = 2'b01;
    reg_write = 1;
    tick();
    reg_write = 0;
  endtask

  task automatic check_perf(input string tag);
`ifdef UCSBECE154A_MC_PERF_EN
    exp2({tag, "_mcycle"}, cyc_model, cyc_model);
    obs2(mcyc32, mcyc16);
    exp2({tag, "_minstret"}, inst_model, inst_model);
    obs2(minst32, minst16);
`else
    exp2({tag, "_mcycle"}, 64'd0, 64'd0);
    obs2(mcyc32, mcyc16);
    exp2({tag, "_minstret"}, 64'd0, 64'd0);
    obs2(minst32, minst16);
`endif
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
  } imm_case_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
  } alu_case_t;

  initial begin
    imm_case_t imm_tbl[7];
    alu_case_t alu_tbl[5];
    imm_tbl[0] = '{3'b000, 32'hFFFF_F800};
    imm_tbl[1] = '{3'b001, 32'hFFFF_F81F};
    imm_tbl[2] = '{3'b010, 32'hFFFF_F81E};
    imm_tbl[3] = '{3'b011, 32'hFFF0_0000};
    imm_tbl[4] = '{3'b100, 32'h8000_0000};
    imm_tbl[5] = '{3'b101, 32'h0000_0000};
    imm_tbl[6] = '{3'b111, 32'h0000_0000};
    alu_tbl[0] = '{3'b001, 32'd0,  1'b1};
    alu_tbl[1] = '{3'b000, 32'd10, 1'b0};
    alu_tbl[2] = '{3'b101, 32'd0,  1'b1};
    alu_tbl[3] = '{3'b011, 32'd5,  1'b0};
    alu_tbl[4] = '{3'b010, 32'd5,  1'b0};

    idle();
    rdata = 32'd0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    exp2("rst_pc", 64'h100, 64'h100);        obs2(pc32, pc16);
    exp2("rst_ir", 64'h13, 64'h13);          obs2(instr32, instr16);
    exp2("rst_b", 64'd0, 64'd0);             obs2(wdata32, wdata16);
    adr_src = 1; res_src = 2'b00; #1;
    exp2("rst_aluout", 64'd0, 64'd0);        obs2(addr32, addr16);
    res_src = 2'b01; #1;
    exp2("rst_data", 64'd0, 64'd0);          obs2(addr32, addr16);
    show_a();
    exp2("rst_a", 64'd0, 64'd0);             obs2(addr32, addr16);
    check_perf("rst");

    // Fetch of addi x1,x0,5 from RESET_PC.
    idle();
    fetch_ctl();
    rdata = 32'h0050_0093;
    #1;
    exp2("fetch_addr", 64'h100, 64'h100);    obs2(addr32, addr16);
    exp2("fetch_ir", 64'h0050_0093, 64'h0050_0093);
    exp2("fetch_pc", 64'h104, 64'h104);
    tick();
    obs2(instr32, instr16);
    obs2(pc32, pc16);
    idle();
    src_a = 2'b01; src_b = 2'b11; res_src = 2'b10; adr_src = 1; #1;
    exp2("old_pc", 64'h100, 64'h100);        obs2(addr32, addr16);

    // Decode, execute, writeback.
    idle();
    tick();
    src_a = 2'b10; src_b = 2'b01; imm_src = 3'b000; res_src = 2'b11; adr_src = 1; #1;
    exp2("addi_imm", 64'd5, 64'd5);          obs2(addr32, addr16);
    tick();
    idle();
    res_src = 2'b00; adr_src = 1; reg_write = 1; instr_done = 1; #1;
    exp2("addi_aluout", 64'd5, 64'd5);       obs2(addr32, addr16);
    tick();
    idle();
    check_perf("addi");
    read_reg(5'd1, 32'd5, 32'd5);
    write_reg(5'd0, 32'hBEEF);
    read_reg(5'd0, 32'd0, 32'd0);

    // Three stalled fetch cycles.
    idle();
    fetch_ctl();
    mem_ready = 0;
    rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      exp2($sformatf("stall%0d_pc", i), 64'h104, 64'h104);
      exp2($sformatf("stall%0d_ir", i), 64'h13, 64'h13);
      tick();
      obs2(pc32, pc16);
      obs2(instr32, instr16);
    end
    check_perf("stall");
    idle();

    // Immediate formats.
    load_ir(32'h8000_0F80);
    res_src = 2'b11; adr_src = 1;
    for (int i = 0; i < 7; i++) begin
      imm_src = imm_tbl[i].sel;
      exp2($sformatf("imm_sel%0d", imm_tbl[i].sel), {32'd0, imm_tbl[i].imm}, {32'd0, imm_tbl[i].imm});
      #1;
      obs2(addr32, addr16);
    end
    load_ir(32'h7FF0_0000);
    res_src = 2'b11; adr_src = 1; imm_src = 3'b000; #1;
    exp2("imm_i_pos", 64'h7FF, 64'h7FF);     obs2(addr32, addr16);
    imm_src = 3'b011; #1;
    exp2("imm_j_pos", 64'hFFE, 64'hFFE);     obs2(addr32, addr16);

    // ALU operations with A = x1 = 5 and B = imm 5.
    load_ir(32'h0050_8093);
    tick();
    src_a = 2'b10; src_b = 2'b01; imm_src = 3'b000; res_src = 2'b10; adr_src = 1;
    for (int i = 0; i < 5; i++) begin
      alu_ctl = alu_tbl[i].op;
      exp2($sformatf("alu%0d_res", alu_tbl[i].op), {32'd0, alu_tbl[i].res}, {32'd0, alu_tbl[i].res});
      exp2($sformatf("alu%0d_zero", alu_tbl[i].op), {63'd0, alu_tbl[i].zero}, {63'd0, alu_tbl[i].zero});
      #1;
      obs2(addr32, addr16);
      obs2({63'd0, zero32}, {63'd0, zero16});
    end

    // Write x3 on the same edge that reads x3: A must get the old value.
    load_ir(32'h0001_8193);
    rdata = 32'h77;
    tick();
    res_src = 2'b01; reg_write = 1;
    tick();
    show_a();
    exp2("nobypass_old", 64'd0, 64'd0);      obs2(addr32, addr16);
    tick();
    exp2("nobypass_new", 64'h77, 64'h77);    obs2(addr32, addr16);

    // Registers above x15 exist only in the RV32I instance.
    write_reg(5'd17, 32'hDEAD);
    read_reg(5'd17, 32'hDEAD, 32'd0);
    read_reg(5'd1, 32'd5, 32'd5);

    // PC wrap: load 0xFFFF_FFFC, then PC+4.
    idle();
    rdata = 32'hFFFF_FFFC;
    tick();
    res_src = 2'b01; pc_write = 1;
    tick();
    exp2("pc_top", 64'hFFFF_FFFC, 64'hFFFF_FFFC);  obs2(pc32, pc16);
    idle();
    src_a = 2'b00; src_b = 2'b10; res_src = 2'b10; adr_src = 1; pc_write = 1; #1;
    exp2("pc_plus4_wrap", 64'd0, 64'd0);     obs2(addr32, addr16);
    tick();
    exp2("pc_wrapped", 64'd0, 64'd0);        obs2(pc32, pc16);
    idle();

`ifdef UCSBECE154A_MC_PERF_EN
    u_dut.mcycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    push("mcycle_wrap_32", 64'd0);
    tick();
    pop_check(mcyc32);
`endif

    // Asynchronous reset in the middle of a stalled fetch.
    fetch_ctl();
    mem_ready = 0;
    @(posedge clk);
    #3 reset = 1;
    #1;
    exp2("areset_pc", 64'h100, 64'h100);     obs2(pc32, pc16);
    exp2("areset_ir", 64'h13, 64'h13);       obs2(instr32, instr16);
    check_perf("areset");
    tick();
    #2 reset = 0;
    idle();
    read_reg(5'd1, 32'd0, 32'd0);
    read_reg(5'd17, 32'd0, 32'd0);
    exp2("post_reset_pc", 64'h100, 64'h100); obs2(pc32, pc16);

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
